// File: rtl/mac_pipe_if.sv
// mac_pipe_if: operand-beat and result handshake bundle for mac_pipe_unit.
// The unit connects through the slave modport; the producer/consumer uses master.
`timescale 1ns/1ps
interface mac_pipe_if #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 2 * WIDTH + 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             first;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             ovf;

    modport master (
        output in_valid, a, b, is_signed, first, last, out_ready,
        input  in_ready, out_valid, out_data, ovf
    );

    modport slave (
        input  in_valid, a, b, is_signed, first, last, out_ready,
        output in_ready, out_valid, out_data, ovf
    );
endinterface

// File: rtl/mac_pipe_unit.sv
// mac_pipe_unit: pipelined multiply-accumulate emitting one dot product per first..last run of beats.
// Build option: define MAC_PIPE_SAT_EN to saturate the accumulator on overflow instead of wrapping.
`timescale 1ns/1ps
module mac_pipe_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int ACC_W  = 2 * WIDTH + 8
) (
    input logic       clk,
    input logic       rst,
    mac_pipe_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    logic              stall_s;
    logic              in_ready_s;
    logic              accept_s;
    logic [PW-1:0]     a_ext_s;
    logic [PW-1:0]     b_ext_s;
    logic [PW-1:0]     prod_s;

    logic [STAGES-1:0] st_valid_r;
    logic [STAGES-1:0] st_first_r;
    logic [STAGES-1:0] st_last_r;
    logic [STAGES-1:0] st_sgn_r;
    logic [PW-1:0]     st_prod_r [STAGES];

    logic              tail_valid_s;
    logic              tail_first_s;
    logic              tail_last_s;
    logic              tail_sgn_s;
    logic [PW-1:0]     tail_prod_s;

    logic              ext_s;
    logic [ACC_W-1:0]  prod_ext_s;
    logic [ACC_W-1:0]  base_s;
    logic              base_ovf_s;
    logic [ACC_W:0]    sum_s;
    logic              ovf_now_s;
    logic              ovf_next_s;
    logic [ACC_W-1:0]  acc_next_s;

    logic [ACC_W-1:0]  acc_r;
    logic              acc_ovf_r;
    logic              closed_r;
    logic              out_valid_r;
    logic [ACC_W-1:0]  out_data_r;
    logic              out_ovf_r;

`ifdef MAC_PIPE_SAT_EN
    // Clamp value for an overflowing sum; neg is the true sign of the widened signed sum.
    function automatic logic [ACC_W-1:0] sat_value(input logic sgn, input logic neg);
        logic [ACC_W-1:0] v;
        v = '1;
        if (sgn) begin
            v = neg ? '0 : '1;
            v[ACC_W-1] = neg;
        end
        return v;
    endfunction
`endif

    // Handshake: a result the consumer does not take freezes the whole unit.
    always_comb begin
        stall_s    = out_valid_r & ~bus.out_ready;
        in_ready_s = ~rst & ~stall_s;
        accept_s   = bus.in_valid & in_ready_s;
    end

    assign bus.in_ready = in_ready_s;

    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of that product are exact either way.
    always_comb begin
        a_ext_s = {{WIDTH{bus.is_signed & bus.a[WIDTH-1]}}, bus.a};
        b_ext_s = {{WIDTH{bus.is_signed & bus.b[WIDTH-1]}}, bus.b};
        prod_s  = a_ext_s * b_ext_s;
    end

    // Stage valid bits: cleared by reset, shifted whenever the unit is not stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid_r <= '0;
        end else if (!stall_s) begin
            st_valid_r[0] <= accept_s;
            for (int i = 1; i < STAGES; i++) begin
                st_valid_r[i] <= st_valid_r[i-1];
            end
        end
    end

    // Product and beat tags travel alongside their valid bit.
    always_ff @(posedge clk) begin
        if (!stall_s) begin
            st_prod_r[0]  <= prod_s;
            st_first_r[0] <= bus.first;
            st_last_r[0]  <= bus.last;
            st_sgn_r[0]   <= bus.is_signed;
            for (int i = 1; i < STAGES; i++) begin
                st_prod_r[i]  <= st_prod_r[i-1];
                st_first_r[i] <= st_first_r[i-1];
                st_last_r[i]  <= st_last_r[i-1];
                st_sgn_r[i]   <= st_sgn_r[i-1];
            end
        end
    end

    assign tail_valid_s = st_valid_r[STAGES-1];
    assign tail_first_s = st_first_r[STAGES-1];
    assign tail_last_s  = st_last_r[STAGES-1];
    assign tail_sgn_s   = st_sgn_r[STAGES-1];
    assign tail_prod_s  = st_prod_r[STAGES-1];

    // Accumulate: one extra bit catches signed overflow and unsigned carry in the same adder.
    always_comb begin
        ext_s                  = tail_sgn_s & tail_prod_s[PW-1];
        prod_ext_s             = {ACC_W{ext_s}};
        prod_ext_s[PW-1:0]     = tail_prod_s;
        if (tail_first_s || closed_r) begin
            // A closed sum never seeds the next dot product, even without first.
            base_s     = '0;
            base_ovf_s = 1'b0;
        end else begin
            base_s     = acc_r;
            base_ovf_s = acc_ovf_r;
        end
        sum_s = {tail_sgn_s & base_s[ACC_W-1], base_s}
              + {tail_sgn_s & prod_ext_s[ACC_W-1], prod_ext_s};
        if (tail_sgn_s) begin
            ovf_now_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
        end else begin
            ovf_now_s = sum_s[ACC_W];
        end
        ovf_next_s = base_ovf_s | ovf_now_s;
`ifdef MAC_PIPE_SAT_EN
        if (ovf_now_s) begin
            acc_next_s = sat_value(tail_sgn_s, sum_s[ACC_W]);
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
`else
        acc_next_s = sum_s[ACC_W-1:0];
`endif
    end

    // Accumulator and result register; a completing sum may replace a result handed off this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= '0;
            acc_ovf_r   <= 1'b0;
            closed_r    <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            if (!stall_s && tail_valid_s) begin
                acc_r     <= acc_next_s;
                acc_ovf_r <= ovf_next_s;
                closed_r  <= tail_last_s;
            end
            if (!stall_s && tail_valid_s && tail_last_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= acc_next_s;
                out_ovf_r   <= ovf_next_s;
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.ovf       = out_ovf_r;

endmodule

// File: tb/tb_mac_pipe_unit.sv
// tb_mac_pipe_unit: directed scenarios plus a randomized run scored against an integer dot-product model.
`timescale 1ns/1ps
module tb_mac_pipe_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mac_pipe_if #(.WIDTH(32), .ACC_W(72)) bus ();
    mac_pipe_if #(.WIDTH(8), .ACC_W(16)) bus8 ();

    mac_pipe_unit #(.WIDTH(32), .STAGES(3), .ACC_W(72)) dut (.clk(clk), .rst(rst), .bus(bus));
    mac_pipe_unit #(.WIDTH(8), .STAGES(2), .ACC_W(16)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {logic [31:0] a; logic [31:0] b; bit sgn; bit first; bit last;} beat_t;
    typedef struct {logic [71:0] d; bit o;} res_t;

    logic signed [127:0] m_acc;
    bit                  m_ovf;
    bit                  m_open;
    res_t                exp_q[$];

    function automatic logic signed [127:0] to_int(input logic [31:0] v, input bit sgn);
        logic signed [127:0] r;
        logic signed [127:0] one;
        one = 128'sd1;
        r = {96'd0, v};
        if (sgn && v[31]) r = r - (one <<< 32);
        return r;
    endfunction

    // Exact-integer model of one accepted beat on the 32-bit / 72-bit unit.
    task automatic model_accept(input beat_t bt);
        logic signed [127:0] one, p, base, ex, hi, lo, v, mask;
        res_t r;
        one  = 128'sd1;
        mask = (one <<< 72) - one;
        p = to_int(bt.a, bt.sgn) * to_int(bt.b, bt.sgn);
        if (bt.first || !m_open) begin
            base  = 128'sd0;
            m_ovf = 1'b0;
        end else begin
            base = m_acc;
        end
        ex = base + p;
        if (bt.sgn) begin
            hi = (one <<< 71) - one;
            lo = -(one <<< 71);
        end else begin
            hi = mask;
            lo = 128'sd0;
        end
        v = ex;
        if (ex > hi || ex < lo) begin
            m_ovf = 1'b1;
`ifdef MAC_PIPE_SAT_EN
            v = (ex > hi) ? hi : lo;
`else
            v = ex & mask;
            if (bt.sgn && v[71]) v = v - (one <<< 72);
`endif
        end
        m_acc = v;
        if (bt.last) begin
            r.d = v[71:0];
            r.o = m_ovf;
            exp_q.push_back(r);
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input bit sgn, input bit f, input bit l);
        int n;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.is_signed = sgn; bus.first = f; bus.last = l;
        bus.in_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL send_beat_ready: in_ready got %b want 1", bus.in_ready);
        else n_pass++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit sgn, input bit f, input bit l);
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.is_signed = sgn; bus8.first = f; bus8.last = l;
        bus8.in_valid = 1'b1;
        #1;
        n_checks++;
        if (bus8.in_ready !== 1'b1) $display("FAIL send8_ready: in_ready got %b want 1", bus8.in_ready);
        else n_pass++;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic wait8();
        int n;
        n = 0;
        while (bus8.out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 72'd0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else n_pass++;
        n_checks++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.ovf); else n_pass++;
        n_checks++; if (bus8.out_valid !== 1'b0) $display("FAIL reset_out_valid8: got %b want 0", bus8.out_valid); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_single_unsigned();
        int n;
        bus.out_ready = 1'b1;
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
        wait_valid(n);
        // Edges counted after the accepting edge; the result lands on edge STAGES.
        n_checks++; if (n !== 3) $display("FAIL single_latency: got %0d want 3", n); else n_pass++;
        n_checks++; if (bus.out_data !== 72'h00_FFFF_FFFE_0000_0001) $display("FAIL single_data: got %h want 00fffffffe00000001", bus.out_data); else n_pass++;
        n_checks++; if (bus.ovf !== 1'b0) $display("FAIL single_ovf: got %b want 0", bus.ovf); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_drop: out_valid got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_signed_dot();
        int n, pulses;
        logic [71:0] neg35;
        bus.out_ready = 1'b1;
        send_beat(32'd3, -32'sd2, 1'b1, 1'b1, 1'b0);
        send_beat(-32'sd7, 32'd5, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        send_beat(32'd100, 32'd100, 1'b1, 1'b0, 1'b0);
        send_beat(-32'sd1, -32'sd1, 1'b1, 1'b0, 1'b1);
        wait_valid(n);
        n_checks++; if (bus.out_data !== 72'd9960) $display("FAIL signed_dot_data: got %h want %h", bus.out_data, 72'd9960); else n_pass++;
        n_checks++; if (bus.ovf !== 1'b0) $display("FAIL signed_dot_ovf: got %b want 0", bus.ovf); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        n_checks++; if (pulses !== 1) $display("FAIL signed_dot_pulses: got %0d want 1", pulses); else n_pass++;
        neg35 = 72'd0 - 72'd35;
        send_beat(-32'sd5, 32'd7, 1'b1, 1'b1, 1'b1);
        wait_valid(n);
        n_checks++; if (bus.out_data !== neg35) $display("FAIL signed_neg_data: got %h want %h", bus.out_data, neg35); else n_pass++;
        // first=0 after a closed result must start from zero, not from -35.
        send_beat(32'd2, 32'd3, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        wait_valid(n);
        n_checks++; if (bus.out_data !== 72'd6) $display("FAIL first_zero_data: got %h want 6", bus.out_data); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        bus.out_ready = 1'b0;
        send_beat(32'd10, 32'd20, 1'b0, 1'b1, 1'b0);
        send_beat(32'd30, 32'd40, 1'b0, 1'b0, 1'b1);
        send_beat(32'd5, 32'd6, 1'b0, 1'b1, 1'b0);
        send_beat(32'd7, 32'd8, 1'b0, 1'b0, 1'b1);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_stall_ready: got %b want 0", bus.in_ready); else n_pass++;
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 72'd1400) $display("FAIL b2b_hold: valid %b data %h want 1 / %h", bus.out_valid, bus.out_data, 72'd1400); else n_pass++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        wait_valid(n);
        n_checks++; if (bus.out_data !== 72'd86) $display("FAIL b2b_second: got %h want %h", bus.out_data, 72'd86); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        int n, pulses;
        bus.out_ready = 1'b1;
        send_beat(32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
        send_beat(32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", bus.in_ready); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b0) pulses++;
            @(posedge clk); #1;
        end
        n_checks++; if (pulses !== 0) $display("FAIL midrst_no_output: valid cycles got %0d want 0", pulses); else n_pass++;
        send_beat(32'd6, 32'd7, 1'b0, 1'b1, 1'b1);
        wait_valid(n);
        n_checks++; if (bus.out_data !== 72'd42 || bus.ovf !== 1'b0) $display("FAIL midrst_42: got %h ovf %b want %h ovf 0", bus.out_data, bus.ovf, 72'd42); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow_8();
        logic [15:0] exp_u, exp_s;
`ifdef MAC_PIPE_SAT_EN
        exp_u = 16'hFFFF; exp_s = 16'h7FFF;
`else
        exp_u = 16'hFC02; exp_s = 16'h8000;
`endif
        bus8.out_ready = 1'b1;
        send8(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
        send8(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        wait8();
        n_checks++; if (bus8.out_data !== exp_u || bus8.ovf !== 1'b1) $display("FAIL ovf8_unsigned: got %h ovf %b want %h ovf 1", bus8.out_data, bus8.ovf, exp_u); else n_pass++;
        send8(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
        send8(8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
        wait8();
        n_checks++; if (bus8.out_data !== exp_s || bus8.ovf !== 1'b1) $display("FAIL ovf8_signed: got %h ovf %b want %h ovf 1", bus8.out_data, bus8.ovf, exp_s); else n_pass++;
        send8(8'd1, 8'd1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        wait8();
        n_checks++; if (bus8.out_data !== 16'd1 || bus8.ovf !== 1'b0) $display("FAIL ovf8_clear: got %h ovf %b want 0001 ovf 0", bus8.out_data, bus8.ovf); else n_pass++;
    endtask

    function automatic logic [31:0] rand_operand();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return 32'hFFFF_FFFF;
        if (k == 1) return 32'h8000_0000;
        return $urandom;
    endfunction

    task automatic test_random();
        beat_t beats[$];
        beat_t bt;
        res_t  r;
        int    bi, got, nres, cyc, len;
        bit    hold, sgn;
        nres = 1000;
        for (int d = 0; d < nres; d++) begin
            len = $urandom_range(1, 4);
            sgn = $urandom_range(0, 1);
            for (int k = 0; k < len; k++) begin
                bt.a = rand_operand();
                bt.b = rand_operand();
                bt.sgn = sgn;
                bt.first = (k == 0) ? ($urandom_range(0, 9) != 0) : 1'b0;
                bt.last = (k == len - 1);
                beats.push_back(bt);
            end
        end
        m_acc = 128'sd0; m_ovf = 1'b0; m_open = 1'b0;
        bi = 0; got = 0; cyc = 0; hold = 1'b0;
        while ((bi < beats.size() || got < nres) && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (!hold) begin
                if (bi < beats.size() && $urandom_range(0, 3) != 0) begin
                    bus.a = beats[bi].a; bus.b = beats[bi].b; bus.is_signed = beats[bi].sgn;
                    bus.first = beats[bi].first; bus.last = beats[bi].last;
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL random_extra_result: got %h want none", bus.out_data);
                end else begin
                    r = exp_q.pop_front();
                    if (bus.out_data !== r.d || bus.ovf !== r.o)
                        $display("FAIL random_result %0d: got %h ovf %b want %h ovf %b", got, bus.out_data, bus.ovf, r.d, r.o);
                    else n_pass++;
                end
                got++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                model_accept(beats[bi]);
                bi++;
                hold = 1'b0;
            end else begin
                hold = bus.in_valid;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++;
        if (got !== nres || bi !== beats.size()) $display("FAIL random_count: results got %0d want %0d", got, nres);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
        bus.first = 1'b0; bus.last = 1'b0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.is_signed = 1'b0;
        bus8.first = 1'b0; bus8.last = 1'b0; bus8.out_ready = 1'b1;
        test_reset();
        test_single_unsigned();
        test_signed_dot();
        test_back_to_back();
        test_reset_midflight();
        test_overflow_8();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/mac_pipe_unit.md
MAC_PIPE_UNIT -- requirements
Module: mac_pipe_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits (legal 4..64).
REQ-002 Parameter STAGES, default 3: multiplier pipeline depth in cycles (legal 1..6).
REQ-003 Parameter ACC_W, default 2*WIDTH+8: accumulator/result width (legal >= 2*WIDTH).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  operand beat offered.
REQ-007 in_ready  out  1  unit accepts a beat this cycle.
REQ-008 a, b  in  WIDTH  multiplicand and multiplier.
REQ-009 is_signed  in  1  1: a and b are two's complement; 0: unsigned; sampled per beat.
REQ-010 first  in  1  beat starts a new dot product; the accumulator is reloaded with this product.
REQ-011 last  in  1  beat ends the dot product; the sum is emitted after it.
REQ-012 out_valid  out  1  result held on out_data.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 out_data  out  ACC_W  accumulated dot product, sign-extended when the closing beat had is_signed=1.
REQ-015 ovf  out  1  sticky overflow for the current dot product, valid with out_data.

Function
REQ-016 Beat accepted when in_valid && in_ready; the full 2*WIDTH product is formed exactly per is_signed.
REQ-017 Product plus first/last/is_signed tags traverse STAGES registered stages; stage valid bits travel with the data.
REQ-018 Accumulate stage: first=1 -> acc = product; else acc = acc + product, computed in ACC_W bits.
REQ-019 Latency: out_valid rises STAGES+1 cycles after acceptance of a last=1 beat when there is no stall.
REQ-020 Stall = out_valid && !out_ready; during a stall the pipeline, accumulator and out_data freeze and in_ready=0.
REQ-021 in_ready=1 whenever there is no stall and rst=0.
REQ-022 out_valid holds with stable out_data and ovf until the out_ready handshake; it drops the next cycle unless another result completes in that same cycle.
REQ-023 A beat with first=1 and last=1 yields a single-product result.
REQ-024 A beat with first=0 following a completed result accumulates onto acc = 0; it does not accumulate onto the previous sum.
REQ-025 Bubbles (in_valid=0) between beats of one dot product have no effect on the sum.
REQ-026 ovf is set when the signed or unsigned ACC_W sum exceeds its range; it clears on a first=1 beat reaching the accumulator.

Reset
REQ-027 With rst=1 at a clock edge: all stage valids=0, acc=0, out_valid=0, out_data=0, ovf=0.
REQ-028 in_ready=0 while rst=1; it is 1 in the first cycle after rst deasserts.
REQ-029 Reset mid-operation discards all in-flight beats and any pending result; no output follows.

Configuration
REQ-030 Macro MAC_PIPE_SAT_EN: when defined, accumulation saturates to the ACC_W maximum/minimum on overflow (signed or unsigned per tag) and ovf is set.
REQ-031 Without MAC_PIPE_SAT_EN, accumulation wraps modulo 2^ACC_W and ovf is still reported.

Verification
REQ-032 WIDTH=32, unsigned single beat a=0xFFFFFFFF, b=0xFFFFFFFF, first=last=1 -> out_data=0xFFFFFFFE00000001 after STAGES+1 cycles, ovf=0.
REQ-033 Signed 4-beat dot product (3,-2),(-7,5),(100,100),(-1,-1) with out_ready=1 -> out_data=9960 (sign-extended), exactly one out_valid pulse.
REQ-034 Back-to-back dot products with out_ready=0 for 5 cycles -> in_ready=0 during the stall, first result held stable, second result correct and not lost.
REQ-035 WIDTH=8, ACC_W=16, unsigned beats 255*255 repeated 2 times -> ovf=1; out_data=0xFFFF with MAC_PIPE_SAT_EN, 0xFC02 without.
REQ-036 rst pulsed while two beats are in flight -> no out_valid afterwards; the next single beat 6*7 gives out_data=42.
REQ-037 Random 1000 dot products (random lengths, bubbles, out_ready toggling) against a reference model -> all results match.
